// File: rtl/rx_cic_ctrl.sv
// rtl/rx_cic_ctrl.sv - rate/reset sequencing, input gating and I/Q re-pairing for the dual-channel RX CIC
module rx_cic_ctrl #(
  parameter int RATE_W       = 10,
  parameter int DATA_W       = 32,
  parameter int RATE_MIN     = 8,
  parameter int RATE_MAX     = 640,
  parameter int DEFAULT_RATE = 160,
  parameter int RESET_CYCLES = 4,
  parameter int FLUSH_PAIRS  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [RATE_W-1:0] rate_req,
  input  logic              rate_req_valid,
  output logic              rate_req_ready,
  output logic              rate_err,
  input  logic              adc_valid,
  output logic              cic_in_valid,
  input  logic              cic_in_ready,
  output logic [RATE_W-1:0] cic_rate,
  output logic              cic_reset_n,
  input  logic [DATA_W-1:0] cic_out_data,
  input  logic              cic_out_valid,
  input  logic              cic_out_channel,
  input  logic [1:0]        cic_out_error,
  output logic              cic_out_ready,
  output logic [DATA_W-1:0] iq_i,
  output logic [DATA_W-1:0] iq_q,
  output logic              iq_valid,
  output logic              pair_err,
  output logic              overrun,
  output logic              locked
);

  typedef enum logic [1:0] {S_HOLD, S_FLUSH, S_RUN} state_t;

  state_t            state, state_nx;
  logic [3:0]        hold_cnt, hold_cnt_nx;
  logic [7:0]        flush_cnt, flush_cnt_nx;
  logic              have_i, have_i_nx;
  logic [DATA_W-1:0] i_hold, i_hold_nx;
  logic [RATE_W-1:0] rate_nx;
  logic              crst_nx, rerr_nx, perr_nx, pair_done;
  logic              req_acc, req_bad, req_new;

  assign rate_req_ready = (state != S_HOLD);
  assign cic_in_valid   = adc_valid && (state != S_HOLD);
  assign cic_out_ready  = 1'b1;

  assign req_acc = rate_req_valid && rate_req_ready;
  assign req_bad = (rate_req < RATE_W'(RATE_MIN)) || (rate_req > RATE_W'(RATE_MAX));
  assign req_new = !req_bad && (rate_req != cic_rate);

  always_comb begin
    state_nx     = state;
    hold_cnt_nx  = hold_cnt;
    flush_cnt_nx = flush_cnt;
    have_i_nx    = have_i;
    i_hold_nx    = i_hold;
    rate_nx      = cic_rate;
    crst_nx      = cic_reset_n;
    rerr_nx      = 1'b0;
    perr_nx      = 1'b0;
    pair_done    = 1'b0;

    // Output beats during HOLD belong to the decimator's reset transient.
    if (state == S_HOLD) begin
      have_i_nx = 1'b0;
    end else if (cic_out_valid) begin
      if (cic_out_error != 2'b00) begin
        have_i_nx = 1'b0;
        perr_nx   = 1'b1;
      end else if (!cic_out_channel) begin
        i_hold_nx = cic_out_data;
        have_i_nx = 1'b1;
        perr_nx   = have_i;
      end else if (have_i) begin
        pair_done = 1'b1;
        have_i_nx = 1'b0;
      end else begin
        perr_nx = 1'b1;
      end
    end

    case (state)
      S_HOLD: begin
        crst_nx     = 1'b0;
        hold_cnt_nx = hold_cnt + 4'd1;
        if (hold_cnt == 4'(RESET_CYCLES - 1)) begin
          state_nx     = S_FLUSH;
          flush_cnt_nx = 8'd0;
          crst_nx      = 1'b1;
        end
      end
      S_FLUSH: begin
        if (pair_done) begin
          flush_cnt_nx = flush_cnt + 8'd1;
          if (flush_cnt == 8'(FLUSH_PAIRS - 1)) state_nx = S_RUN;
        end
      end
      default: ;
    endcase

    // A real rate change overrides everything, including flush completion.
    if (req_acc) begin
      if (req_bad) begin
        rerr_nx = 1'b1;
      end else if (req_new) begin
        rate_nx     = rate_req;
        state_nx    = S_HOLD;
        hold_cnt_nx = 4'd0;
        have_i_nx   = 1'b0;
        crst_nx     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_HOLD;
      hold_cnt    <= 4'd0;
      flush_cnt   <= 8'd0;
      have_i      <= 1'b0;
      i_hold      <= '0;
      cic_rate    <= RATE_W'(DEFAULT_RATE);
      cic_reset_n <= 1'b0;
      iq_i        <= '0;
      iq_q        <= '0;
      iq_valid    <= 1'b0;
      pair_err    <= 1'b0;
      rate_err    <= 1'b0;
      overrun     <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state       <= state_nx;
      hold_cnt    <= hold_cnt_nx;
      flush_cnt   <= flush_cnt_nx;
      have_i      <= have_i_nx;
      i_hold      <= i_hold_nx;
      cic_rate    <= rate_nx;
      cic_reset_n <= crst_nx;
      iq_valid    <= pair_done && (state == S_RUN);
      if (pair_done && (state == S_RUN)) begin
        iq_i <= i_hold;
        iq_q <= cic_out_data;
      end
      pair_err    <= perr_nx;
      rate_err    <= rerr_nx;
      overrun     <= cic_in_valid && !cic_in_ready;
      locked      <= (state_nx == S_RUN);
    end
  end

endmodule
